ball_engine: RTL and testbench
==============================

BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning LED grid size (power of 2, >=8); localparam W = clog2(N).
REQ-002 The module SHALL have parameter TICK_DIV, default 25000000, meaning clocks per ball step (>=2).
REQ-003 The module SHALL have parameter PADDLE_LEN, default 3, meaning paddle height in rows (1..N).
REQ-004 The module SHALL have port clk, input, width 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n, input, width 1, meaning reset; reset is synchronous and active-low.
REQ-006 The module SHALL have port serve, input, width 1, meaning a serve request, sampled each cycle.
REQ-007 The module SHALL have port serve_dir, input, width 1, meaning initial x direction (0 = left, 1 = right).
REQ-008 The module SHALL have port on, input, width 1, meaning display enable.
REQ-009 The module SHALL have port paddle_l_y, input, width W, meaning top row of the left paddle (column 0).
REQ-010 The module SHALL have port paddle_r_y, input, width W, meaning top row of the right paddle (column N-1).
REQ-011 The module SHALL have port Sx, output, width N, meaning one-hot active-high column select of the ball.
REQ-012 The module SHALL have port Sy, output, width N, meaning one-hot active-low row select of the ball.
REQ-013 The module SHALL have ports ball_x and ball_y, output, width W each, meaning current ball position.
REQ-014 The module SHALL have ports miss_l and miss_r, output, width 1 each, meaning one-cycle miss pulses.
REQ-015 The module SHALL have port busy, output, width 1, meaning high whenever the state is not IDLE.

Function
REQ-016 The state machine SHALL have states IDLE, PLAY and MISS.
REQ-017 In IDLE, the ball SHALL be parked at x=N/2, y=N/2 and the tick counter SHALL be held at 0.
REQ-018 serve=1 in IDLE SHALL cause: next cycle state=PLAY, dx=serve_dir, dy=+1 (down), tick counter starts at 0.
REQ-019 serve SHALL be ignored in PLAY and MISS.
REQ-020 The tick counter SHALL count 0..TICK_DIV-1 and wrap; a step SHALL occur on the cycle it equals TICK_DIV-1, so the first step occurs TICK_DIV cycles after the serve is accepted.
REQ-021 Y motion per step: y+dy; at y=N-1 with dy=+1, dy SHALL flip and y SHALL become N-2; at y=0 with dy=-1, dy SHALL flip and y SHALL become 1; y SHALL never wrap.
REQ-022 The ball SHALL move in columns 1..N-2 only during PLAY; X motion is x+dx except at the paddle columns.
REQ-023 Left paddle: at x=1 with dx=-1, hit iff paddle_l_y <= y <= min(paddle_l_y+PADDLE_LEN-1, N-1), using y before the step; on hit dx SHALL flip and x SHALL become 2.
REQ-024 Left miss: at x=1 with dx=-1 and no hit, x SHALL become 0, miss_l SHALL pulse for exactly one cycle, and state SHALL become MISS.
REQ-025 The right paddle SHALL mirror REQ-023/REQ-024 at x=N-2 with dx=+1, using paddle_r_y, x = N-3 on hit, x = N-1 on miss, and miss_r.
REQ-026 When a Y bounce and an X paddle event occur in the same step, both SHALL be applied in that step.
REQ-027 MISS SHALL hold the ball at the miss column for one full tick period, then go to IDLE with the ball re-centered.
REQ-028 Sx/Sy SHALL be registered decodes of ball_x/ball_y, lagging the position by one cycle.
REQ-029 When on=0, Sx SHALL be all 0s and Sy SHALL be all 1s; position updates SHALL continue regardless of on.
REQ-030 All arithmetic SHALL be W-bit unsigned, and no intermediate value SHALL leave the range 0..N-1.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force: state=IDLE, tick counter=0, ball_x=ball_y=N/2, dx=1, dy=+1, Sx=0, Sy all 1s, miss_l=miss_r=busy=0.
REQ-032 Reset SHALL take priority over serve and step events, including when asserted mid-PLAY or mid-MISS.

Verification (N=8, TICK_DIV=4, PADDLE_LEN=3)
REQ-033 Reset then on=1 -> ball (4,4), Sx=00010000, Sy=11101111, busy=0.
REQ-034 serve=1, serve_dir=1 -> busy=1 next cycle; 4 cycles later ball=(5,5); Sx/Sy update one cycle after that.
REQ-035 Ball at y=7 with dy=+1 on a step -> y=6 and dy=-1; at y=0 with dy=-1 -> y=1.
REQ-036 Ball (1,3), dx=-1, paddle_l_y=2 -> x=2, dx=+1, no miss; same with paddle_l_y=5 -> x=0, single-cycle miss_l pulse, MISS state, then IDLE at (4,4) after 4 cycles.
REQ-037 Corner case: ball (6,7), dx=+1, dy=+1, paddle_r_y=6 -> next step (5,6), both directions flipped; paddle_r_y=7 clips at row 7 and still hits.
REQ-038 rst_n=0 mid-PLAY, coincident with a step and serve -> IDLE at (4,4), no miss pulse; on=0 -> Sx=0, Sy=11111111 while the position keeps stepping.

Source files
------------

// File: rtl/ball_engine.sv
// Pong ball engine: steps a ball across an N x N LED grid, bounces off the top
// and bottom walls and two paddles, and drives registered one-hot row/column selects.
module ball_engine #(
  parameter int N          = 8,
  parameter int TICK_DIV   = 25000000,
  parameter int PADDLE_LEN = 3,
  localparam int W         = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         serve,
  input  logic         serve_dir,
  input  logic         on,
  input  logic [W-1:0] paddle_l_y,
  input  logic [W-1:0] paddle_r_y,
  output logic [N-1:0] Sx,
  output logic [N-1:0] Sy,
  output logic [W-1:0] ball_x,
  output logic [W-1:0] ball_y,
  output logic         miss_l,
  output logic         miss_r,
  output logic         busy
);

  localparam int TW = $clog2(TICK_DIV);

  localparam logic [TW-1:0] C_TMAX = TW'(TICK_DIV - 1);
  localparam logic [W-1:0]  C_MID  = W'(N / 2);
  localparam logic [W-1:0]  C_MAX  = W'(N - 1);
  localparam logic [W-1:0]  C_NM2  = W'(N - 2);
  localparam logic [W-1:0]  C_NM3  = W'(N - 3);
  localparam logic [W-1:0]  C_ONE  = W'(1);
  localparam logic [W-1:0]  C_TWO  = W'(2);
  localparam logic [W-1:0]  C_PLEN = W'(PADDLE_LEN - 1);
  localparam logic [N-1:0]  C_BIT0 = N'(1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_MISS} state_t;

  state_t        r_state, w_state_nx;
  logic [TW-1:0] r_tick, w_tick_nx;
  logic [W-1:0]  r_x, r_y, w_x_nx, w_y_nx;
  logic          r_dx, r_dy, w_dx_nx, w_dy_nx;
  logic          r_miss_l, r_miss_r, w_miss_l_nx, w_miss_r_nx;
  logic [N-1:0]  r_sx, r_sy;
  logic          w_step, w_hit_l, w_hit_r;
  logic [W-1:0]  w_dl, w_dr;

  assign w_step = (r_tick == C_TMAX);

  // Offset into the paddle never exceeds N-1, so the clipped bottom row needs no extra term.
  assign w_dl    = r_y - paddle_l_y;
  assign w_dr    = r_y - paddle_r_y;
  assign w_hit_l = (r_y >= paddle_l_y) && (w_dl <= C_PLEN);
  assign w_hit_r = (r_y >= paddle_r_y) && (w_dr <= C_PLEN);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_tick_nx   = r_tick;
    w_x_nx      = r_x;
    w_y_nx      = r_y;
    w_dx_nx     = r_dx;
    w_dy_nx     = r_dy;
    w_miss_l_nx = 1'b0;
    w_miss_r_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tick_nx = '0;
        w_x_nx    = C_MID;
        w_y_nx    = C_MID;
        if (serve) begin
          w_state_nx = S_PLAY;
          w_dx_nx    = serve_dir;
          w_dy_nx    = 1'b1;
        end
      end
      S_PLAY: begin
        w_tick_nx = w_step ? '0 : r_tick + TW'(1);
        if (w_step) begin
          if (r_dy && (r_y == C_MAX)) begin
            w_y_nx  = C_NM2;
            w_dy_nx = 1'b0;
          end else if (!r_dy && (r_y == '0)) begin
            w_y_nx  = C_ONE;
            w_dy_nx = 1'b1;
          end else if (r_dy) begin
            w_y_nx = r_y + C_ONE;
          end else begin
            w_y_nx = r_y - C_ONE;
          end

          if (!r_dx && (r_x == C_ONE)) begin
            if (w_hit_l) begin
              w_x_nx  = C_TWO;
              w_dx_nx = 1'b1;
            end else begin
              w_x_nx      = '0;
              w_miss_l_nx = 1'b1;
              w_state_nx  = S_MISS;
            end
          end else if (r_dx && (r_x == C_NM2)) begin
            if (w_hit_r) begin
              w_x_nx  = C_NM3;
              w_dx_nx = 1'b0;
            end else begin
              w_x_nx      = C_MAX;
              w_miss_r_nx = 1'b1;
              w_state_nx  = S_MISS;
            end
          end else if (r_dx) begin
            w_x_nx = r_x + C_ONE;
          end else begin
            w_x_nx = r_x - C_ONE;
          end
        end
      end
      S_MISS: begin
        w_tick_nx = w_step ? '0 : r_tick + TW'(1);
        if (w_step) begin
          w_state_nx = S_IDLE;
          w_x_nx     = C_MID;
          w_y_nx     = C_MID;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick   <= '0;
      r_x      <= C_MID;
      r_y      <= C_MID;
      r_dx     <= 1'b1;
      r_dy     <= 1'b1;
      r_miss_l <= 1'b0;
      r_miss_r <= 1'b0;
      r_sx     <= '0;
      r_sy     <= '1;
    end else begin
      r_tick   <= w_tick_nx;
      r_x      <= w_x_nx;
      r_y      <= w_y_nx;
      r_dx     <= w_dx_nx;
      r_dy     <= w_dy_nx;
      r_miss_l <= w_miss_l_nx;
      r_miss_r <= w_miss_r_nx;
      // Display decode lags the position by one cycle; blanking does not stall motion.
      r_sx     <= on ? (C_BIT0 << r_x) : '0;
      r_sy     <= on ? ~(C_BIT0 << r_y) : '1;
    end
  end

  assign Sx     = r_sx;
  assign Sy     = r_sy;
  assign ball_x = r_x;
  assign ball_y = r_y;
  assign miss_l = r_miss_l;
  assign miss_r = r_miss_r;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine (N=8, TICK_DIV=4, PADDLE_LEN=3): hand-derived
// trajectories are queued up front and a monitor pops one entry per observed event.
module tb_ball_engine;
  localparam int N  = 8;
  localparam int TD = 4;
  localparam int PL = 3;
  localparam int W  = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         serve = 1'b0;
  logic         serve_dir = 1'b0;
  logic         on = 1'b0;
  logic [W-1:0] paddle_l_y = '0;
  logic [W-1:0] paddle_r_y = '0;
  logic [N-1:0] Sx, Sy;
  logic [W-1:0] ball_x, ball_y;
  logic         miss_l, miss_r, busy;

  ball_engine #(.N(N), .TICK_DIV(TD), .PADDLE_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .serve(serve), .serve_dir(serve_dir), .on(on),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .Sx(Sx), .Sy(Sy), .ball_x(ball_x), .ball_y(ball_y),
    .miss_l(miss_l), .miss_r(miss_r), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic       ml;
    logic       mr;
    logic       b;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e, m_a;
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [2:0] px, py;
  logic       pb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int ml, input int mr, input int b);
    exp_t e;
    e.x  = 3'(x);
    e.y  = 3'(y);
    e.ml = 1'(ml);
    e.mr = 1'(mr);
    e.b  = 1'(b);
    q.push_back(e);
  endtask

  task automatic push_xy(input int x, input int y);
    push(x, y, 0, 0, 1);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_serve(input logic d);
    serve     = 1'b1;
    serve_dir = d;
    push(4, 4, 0, 0, 1);
    cyc(1);
    serve = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < lim) begin
      cyc(1);
      i++;
    end
    chk("idle_reached", 32'(busy), 0);
  endtask

  // Event = position change, busy change, or any miss pulse.
  always @(negedge clk) begin
    if (mon_en && (ball_x !== px || ball_y !== py || busy !== pb || miss_l || miss_r)) begin
      m_a = {ball_x, ball_y, miss_l, miss_r, busy};
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got x=%0d y=%0d ml=%b mr=%b busy=%b, expected no event",
                 ball_x, ball_y, miss_l, miss_r, busy);
      end else begin
        m_e = q.pop_front();
        if (m_a !== m_e) begin
          n_fail++;
          $display("FAIL event: got x=%0d y=%0d ml=%b mr=%b busy=%b, expected x=%0d y=%0d ml=%b mr=%b busy=%b",
                   m_a.x, m_a.y, m_a.ml, m_a.mr, m_a.b, m_e.x, m_e.y, m_e.ml, m_e.mr, m_e.b);
        end
      end
    end
    px = ball_x;
    py = ball_y;
    pb = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    on    = 1'b0;
    cyc(2);
    chk("rst_x", 32'(ball_x), 4);
    chk("rst_y", 32'(ball_y), 4);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_miss", 32'({miss_l, miss_r}), 0);
    chk("rst_sx", 32'(Sx), 32'h00);
    chk("rst_sy", 32'(Sy), 32'hff);
    rst_n = 1'b1;
    on    = 1'b1;
    cyc(1);
    chk("idle_sx", 32'(Sx), 32'h10);
    chk("idle_sy", 32'(Sy), 32'hef);
    mon_en = 1'b1;

    // Serve right: right paddle hit at (6,6), bottom bounce, left hit at (1,3), top bounce, right miss
    paddle_l_y = 3'd2;
    paddle_r_y = 3'd4;
    do_serve(1'b1);
    chk("serve_busy", 32'(busy), 1);
    push_xy(5, 5); push_xy(6, 6); push_xy(5, 7); push_xy(4, 6);
    push_xy(3, 5); push_xy(2, 4); push_xy(1, 3); push_xy(2, 2);
    push_xy(3, 1); push_xy(4, 0); push_xy(5, 1); push_xy(6, 2);
    push(7, 3, 0, 1, 1);
    push(4, 4, 0, 0, 0);
    cyc(3);
    chk("pre_step_x", 32'(ball_x), 4);
    cyc(1);
    chk("step1_x", 32'(ball_x), 5);
    chk("step1_y", 32'(ball_y), 5);
    chk("step1_sx_lag", 32'(Sx), 32'h10);
    cyc(1);
    chk("step1_sx", 32'(Sx), 32'h20);
    chk("step1_sy", 32'(Sy), 32'hdf);
    serve = 1'b1;
    cyc(1);
    serve = 1'b0;
    wait_idle(80);
    cyc(2);

    // Serve left: corner hit at (1,7) with clipped paddle, right hit at (6,2), left miss at (1,3)
    paddle_l_y = 3'd6;
    paddle_r_y = 3'd0;
    do_serve(1'b0);
    push_xy(3, 5); push_xy(2, 6); push_xy(1, 7); push_xy(2, 6);
    push_xy(3, 5); push_xy(4, 4); push_xy(5, 3); push_xy(6, 2);
    push_xy(5, 1); push_xy(4, 0); push_xy(3, 1); push_xy(2, 2);
    push_xy(1, 3);
    push(0, 4, 1, 0, 1);
    push(4, 4, 0, 0, 0);
    wait_idle(100);
    cyc(2);

    // Reset coincident with a step and a serve
    do_serve(1'b1);
    cyc(3);
    chk("pre_rst_x", 32'(ball_x), 4);
    rst_n = 1'b0;
    serve = 1'b1;
    push(4, 4, 0, 0, 0);
    cyc(1);
    chk("midrst_x", 32'(ball_x), 4);
    chk("midrst_y", 32'(ball_y), 4);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_miss", 32'({miss_l, miss_r}), 0);
    chk("midrst_sx", 32'(Sx), 32'h00);
    chk("midrst_sy", 32'(Sy), 32'hff);
    rst_n = 1'b1;
    serve = 1'b0;
    cyc(3);
    chk("post_rst_busy", 32'(busy), 0);

    // Display blanked while the ball keeps moving
    on = 1'b0;
    do_serve(1'b0);
    push_xy(3, 5);
    push_xy(2, 6);
    cyc(9);
    chk("blank_x", 32'(ball_x), 2);
    chk("blank_y", 32'(ball_y), 6);
    chk("blank_sx", 32'(Sx), 32'h00);
    chk("blank_sy", 32'(Sy), 32'hff);
    on = 1'b1;
    cyc(1);
    chk("unblank_sx", 32'(Sx), 32'h04);
    chk("unblank_sy", 32'(Sy), 32'hbf);
    rst_n = 1'b0;
    push(4, 4, 0, 0, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
